// File: rtl/seq_detect_mealy_param_pkg.sv
// Shared constants and helpers for the programmable serial sequence detector.
// Patterns and windows are zero-extended to CMP_W bits before comparison.
package seq_det_pkg;

    localparam int unsigned CMP_W = 64;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    function automatic int unsigned len_w(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // True when the low 'len' bits of window and pat agree; bits above len are ignored.
    function automatic logic masked_match(input logic [CMP_W-1:0] window,
                                          input logic [CMP_W-1:0] pat,
                                          input int unsigned      len);
        logic [CMP_W-1:0] mask;
        mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
        return ((window ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_detect_mealy_param_sat_counter.sv
// Saturating up-counter; clr restarts the count, still honouring an increment that cycle.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= W'(inc);
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/seq_detect_mealy_param.sv
// Runtime-programmable Mealy serial sequence detector with selectable overlap
// and a saturating match counter. MAX_LEN must not exceed seq_det_pkg::CMP_W.
module seq_detect_mealy_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          MAX_LEN     = 8,
    parameter int unsigned          CNT_W       = 8,
    parameter logic [MAX_LEN-1:0]   RST_PATTERN = 8'b0000_1001,
    parameter int unsigned          RST_LEN     = 4,
    localparam int unsigned         LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               overlap_en,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cnt_clr,
    output logic               dout,
    output logic               dout_q,
    output logic [CNT_W-1:0]   match_count
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_dout_q;

    logic [MAX_LEN-1:0] w_window;
    logic [LEN_W-1:0]   w_len_m1;
    logic [LEN_W-1:0]   w_cfg_len;
    logic               w_hit;
    logic               w_dout;

    assign w_window  = {r_hist, din};
    assign w_len_m1  = r_len - LEN_W'(1);
    assign w_cfg_len = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign w_hit     = masked_match(CMP_W'(w_window), CMP_W'(r_pat), 32'(r_len));

    // fill gates the compare so reset-zeroed history never counts as received bits
    assign w_dout = din_valid & ~cfg_load & (r_fill >= w_len_m1) & w_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat  <= RST_PATTERN;
            r_len  <= LEN_W'(RST_LEN);
            r_hist <= '0;
            r_fill <= '0;
        end else if (cfg_load) begin
            if (cfg_len != '0) begin
                r_pat  <= cfg_pattern;
                r_len  <= w_cfg_len;
                r_hist <= '0;
                r_fill <= '0;
            end
        end else if (din_valid) begin
            r_hist <= w_window[MAX_LEN-2:0];
            if (w_dout && (overlap_en == MODE_NONOVL)) begin
                r_fill <= '0;
            end else if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout_q <= 1'b0;
        end else begin
            r_dout_q <= w_dout;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (reset),
        .clr (cnt_clr),
        .inc (w_dout),
        .q   (match_count)
    );

    assign dout   = w_dout;
    assign dout_q = r_dout_q;

endmodule

// File: tb/tb_seq_detect_mealy_param.sv
// Directed bench for seq_detect_mealy_param: a vector table plus hand-written reset sequences.
// Two instances share stimulus: CNT_W=8 and CNT_W=2 (saturation boundary).
module tb_seq_detect_mealy_param;

    typedef struct packed {
        logic       rst;
        logic       din;
        logic       vld;
        logic       ovl;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       clr;
        logic       e_dout;
        logic       e_q;
        logic [7:0] e_cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       din;
    logic       din_valid;
    logic       overlap_en;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cnt_clr;
    logic       dout;
    logic       dout_q;
    logic [7:0] match_count;
    logic       dout2;
    logic       dout_q2;
    logic [1:0] match_count2;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    seq_detect_mealy_param #(
        .MAX_LEN     (8),
        .CNT_W       (8),
        .RST_PATTERN (8'b0000_1001),
        .RST_LEN     (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .overlap_en  (overlap_en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cnt_clr     (cnt_clr),
        .dout        (dout),
        .dout_q      (dout_q),
        .match_count (match_count)
    );

    seq_detect_mealy_param #(
        .MAX_LEN     (8),
        .CNT_W       (2),
        .RST_PATTERN (8'b0000_1001),
        .RST_LEN     (4)
    ) dut2 (
        .clk         (clk),
        .reset       (reset),
        .din         (din),
        .din_valid   (din_valid),
        .overlap_en  (overlap_en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cnt_clr     (cnt_clr),
        .dout        (dout2),
        .dout_q      (dout_q2),
        .match_count (match_count2)
    );

    task automatic check(input string name, input int row, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic v(input logic rst, input logic d, input logic vld, input logic ovl,
                     input logic ld, input logic [7:0] pat, input logic [3:0] len,
                     input logic clr, input logic ed, input logic eq, input logic [7:0] ec);
        vec_t r;
        r = '{rst, d, vld, ovl, ld, pat, len, clr, ed, eq, ec};
        tbl.push_back(r);
    endtask

    task automatic drive(input vec_t r);
        reset       = r.rst;
        din         = r.din;
        din_valid   = r.vld;
        overlap_en  = r.ovl;
        cfg_load    = r.ld;
        cfg_pattern = r.pat;
        cfg_len     = r.len;
        cnt_clr     = r.clr;
    endtask

    initial begin
        vec_t idle;
        logic [7:0] e2;
        logic [3:0] bits;
        idle = '0;
        drive(idle);
        reset = 1'b1;

        // 1: non-overlap 1001, stream 1,0,0,1,0,0,1
        v(1,0,0,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,0,0,8'h00,4'd0,0, 1,0,0);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,1,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,0,0,0,8'h00,4'd0,0, 0,0,1);
        // 2: overlap, same stream
        v(1,0,0,1,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,1,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,1,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,1,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,1,0,8'h00,4'd0,0, 1,0,0);
        v(0,0,1,1,0,8'h00,4'd0,0, 0,1,1);
        v(0,0,1,1,0,8'h00,4'd0,0, 0,0,1);
        v(0,1,1,1,0,8'h00,4'd0,0, 1,0,1);
        v(0,1,0,1,0,8'h00,4'd0,0, 0,1,2);
        // 3: valid gaps of three cycles between bits
        v(1,0,0,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,0);
        for (int g = 0; g < 3; g++) v(0,1,0,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,0);
        for (int g = 0; g < 3; g++) v(0,1,0,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,0);
        for (int g = 0; g < 3; g++) v(0,1,0,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,0,0,8'h00,4'd0,0, 1,0,0);
        v(0,0,0,0,0,8'h00,4'd0,0, 0,1,1);
        v(0,0,0,0,0,8'h00,4'd0,0, 0,0,1);
        // 4: reset after 1,0,0 then 1,0,0,1
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(1,1,1,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,0);
        v(0,1,1,0,0,8'h00,4'd0,0, 1,0,0);
        v(0,0,0,0,0,8'h00,4'd0,0, 0,1,1);
        // 5: load 1011 with din=1 discarded, overlap stream, ignored len=0 load mid-pattern
        v(0,1,1,1,1,8'h0B,4'd4,0, 0,0,1);
        v(0,1,1,1,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,1,1,0,8'h00,4'd0,0, 0,0,1);
        v(0,1,1,1,0,8'h00,4'd0,0, 0,0,1);
        v(0,1,1,1,0,8'h00,4'd0,0, 1,0,1);
        v(0,0,1,1,0,8'h00,4'd0,0, 0,1,2);
        v(0,1,1,1,0,8'h00,4'd0,0, 0,0,2);
        v(0,0,1,1,1,8'h00,4'd0,0, 0,0,2);
        v(0,1,1,1,0,8'h00,4'd0,0, 1,0,2);
        v(0,0,0,1,0,8'h00,4'd0,0, 0,1,3);
        // 6: len=1 pattern "1", eight 1s, then clear coincident with a match
        v(0,0,0,0,1,8'h01,4'd1,1, 0,0,3);
        for (int k = 0; k < 8; k++) v(0,1,1,0,0,8'h00,4'd0,0, 1,(k != 0),8'(k));
        v(0,1,1,0,0,8'h00,4'd0,1, 1,1,8);
        v(0,0,0,0,0,8'h00,4'd0,0, 0,1,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        // cfg_len=15 clamps to 8: 10110001 matches only on its eighth bit
        v(0,0,1,0,1,8'hB1,4'd15,0, 0,0,1);
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,1,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,0,1,0,0,8'h00,4'd0,0, 0,0,1);
        v(0,1,1,0,0,8'h00,4'd0,0, 1,0,1);
        v(0,0,0,0,0,8'h00,4'd0,0, 0,1,2);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge clk);
            e2 = (tbl[i].e_cnt > 8'd3) ? 8'd3 : tbl[i].e_cnt;
            check("dout", i, {7'd0, dout}, {7'd0, tbl[i].e_dout});
            check("dout_q", i, {7'd0, dout_q}, {7'd0, tbl[i].e_q});
            check("match_count", i, match_count, tbl[i].e_cnt);
            check("dout_w2", i, {7'd0, dout2}, {7'd0, tbl[i].e_dout});
            check("match_count_w2", i, {6'd0, match_count2}, e2);
            @(posedge clk);
            #1;
        end

        // Reset asserted between edges must clear outputs without a clock
        drive(idle);
        @(negedge clk);
        check("cnt_before_async_rst", 1000, match_count, 8'd2);
        #2 reset = 1'b1;
        #1;
        check("cnt_async_rst", 1001, match_count, 8'd0);
        check("cnt2_async_rst", 1002, {6'd0, match_count2}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Programmed pattern must revert to 1001/len 4 after reset
        bits = 4'b1001;
        for (int b = 3; b >= 0; b--) begin
            din       = bits[b];
            din_valid = 1'b1;
            @(negedge clk);
            check("revert_dout", 1010 + b, {7'd0, dout}, {7'd0, (b == 0)});
            @(posedge clk);
            #1;
        end
        drive(idle);
        @(negedge clk);
        check("revert_dout_q", 1020, {7'd0, dout_q}, 8'd1);
        check("revert_cnt", 1021, match_count, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
